// File: rtl/mem_pkg.sv
// mem_pkg: shared sizes and FSM encoding for the memory arbiter
package mem_pkg;
  localparam int NUM_PORTS = 4;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int IDX_W = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts just after last_grant
module rr_arbiter
  import mem_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);
  always_comb begin
    index = last_grant;
    for (int k = NUM_PORTS; k >= 1; k--)
      if (req[last_grant + IDX_W'(k)]) index = last_grant + IDX_W'(k);
  end
  assign valid = |req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: four-client round-robin front end to a multi-port memory controller
module mem_arbiter
  import mem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic [IDX_W-1:0]              mc_state,
  output logic                          mc_en,
  output logic [NUM_PORTS-1:0]          mc_read,
  output logic [NUM_PORTS-1:0]          mc_write,
  output logic [NUM_PORTS*ADDR_W-1:0]   mc_address,
  output logic [NUM_PORTS*DATA_W-1:0]   mc_input_data,
  input  logic [NUM_PORTS*DATA_W-1:0]   mc_output_data
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, gnt_idx;
  logic we_q, we_d, gnt_valid, issue;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] sel;

  rr_arbiter u_rr (.req(req), .last_grant(last_q), .valid(gnt_valid), .index(gnt_idx));

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (gnt_valid) begin
        idx_d = gnt_idx;
        last_d = gnt_idx;
        we_d = we[gnt_idx];
        addr_d = addr[gnt_idx*ADDR_W +: ADDR_W];
        wdata_d = wdata[gnt_idx*DATA_W +: DATA_W];
        state_d = ISSUE;
      end
      ISSUE: state_d = we_q ? RESP : WAIT;
      WAIT: begin
        rdata_d = mc_output_data[idx_q*DATA_W +: DATA_W];
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      last_q <= IDX_W'(NUM_PORTS - 1);
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

  // outputs decode from registered state so reset clears them without a clock
  assign issue = state_q == ISSUE;
  assign sel = NUM_PORTS'(1) << idx_q;
  assign mc_state = idx_q;
  assign mc_en = issue || state_q == WAIT;
  assign mc_write = (issue && we_q) ? sel : '0;
  assign mc_read = (issue && !we_q) ? sel : '0;
  assign mc_address = issue ? (NUM_PORTS*ADDR_W)'(addr_q) << (idx_q*ADDR_W) : '0;
  assign mc_input_data = issue ? (NUM_PORTS*DATA_W)'(wdata_q) << (idx_q*DATA_W) : '0;
  assign ack = state_q == RESP ? sel : '0;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level reference model with random and directed clients
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [3:0] req, we, ack, mc_read, mc_write;
  logic [27:0] addr, mc_address;
  logic [31:0] wdata, mc_input_data, mc_output_data;
  logic [7:0] rdata, last_ack_rdata;
  logic [1:0] mc_state;
  logic mc_en;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .mc_state(mc_state), .mc_en(mc_en),
    .mc_read(mc_read), .mc_write(mc_write), .mc_address(mc_address),
    .mc_input_data(mc_input_data), .mc_output_data(mc_output_data)
  );

  int n_chk, n_pass, mode;
  logic [3:0] cl_req, cl_we, sticky;
  logic [6:0] cl_addr [4];
  logic [7:0] cl_data [4];
  logic [7:0] cmem [128];
  logic [7:0] rmem [128];
  logic [6:0] rd_addr [4];
  int m_ph, m_cl, m_last, m_mcs;
  logic m_we;
  logic [6:0] m_addr;
  logic [7:0] m_data, m_rexp;
  int ack_cnt [4];
  int glog [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int last_ph();
    return m_we ? 2 : 3;
  endfunction

  task automatic apply();
    req = cl_req;
    we = cl_we;
    for (int i = 0; i < 4; i++) begin
      addr[7*i +: 7] = cl_addr[i];
      wdata[8*i +: 8] = cl_data[i];
      mc_output_data[8*i +: 8] = cmem[rd_addr[i]];
    end
  endtask

  task automatic check_outputs();
    logic [3:0] oh, xa;
    oh = 4'b0001 << m_cl;
    xa = (m_ph != 0 && m_ph == last_ph()) ? oh : 4'b0;
    chk("ack", 32'(ack), 32'(xa));
    chk("mc_en", 32'(mc_en), 32'(m_ph == 1 || (m_ph == 2 && !m_we)));
    chk("mc_state", 32'(mc_state), 32'(m_mcs));
    chk("mc_write", 32'(mc_write), 32'((m_ph == 1 && m_we) ? oh : 4'b0));
    chk("mc_read", 32'(mc_read), 32'((m_ph == 1 && !m_we) ? oh : 4'b0));
    if (m_ph == 1) begin
      chk("mc_address", 32'(mc_address), 32'(28'(m_addr) << (7*m_cl)));
      chk("mc_input_data", mc_input_data, 32'(m_data) << (8*m_cl));
    end
    if (xa != 0 && !m_we) chk("rdata", 32'(rdata), 32'(m_rexp));
    for (int i = 0; i < 4; i++)
      if (ack[i]) begin
        ack_cnt[i]++;
        glog.push_back(i);
        last_ack_rdata = rdata;
      end
  endtask

  // shared memory behind the controller; reads present data from the issued address
  task automatic ctrl_update();
    for (int p = 0; p < 4; p++) begin
      if (mc_write[p]) cmem[mc_address[7*p +: 7]] = mc_input_data[8*p +: 8];
      if (mc_read[p]) rd_addr[p] = mc_address[7*p +: 7];
    end
  endtask

  task automatic new_fields(input int i);
    cl_we[i] = 1'($urandom);
    cl_addr[i] = 7'($urandom_range(0, 7));
    cl_data[i] = 8'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bit acked, busy;
      acked = m_ph != 0 && m_ph == last_ph() && m_cl == i;
      busy = m_ph != 0 && m_cl == i && !acked;
      if (acked) begin
        if (!sticky[i] && (mode == 1 || $urandom_range(0, 2) != 0)) cl_req[i] = 1'b0;
        else if (mode == 0) new_fields(i);
      end else if (mode == 0 && !busy && !cl_req[i] && $urandom_range(0, 2) == 0) begin
        cl_req[i] = 1'b1;
        new_fields(i);
      end else if (mode == 0 && busy && cl_req[i] && $urandom_range(0, 3) == 0)
        cl_req[i] = 1'b0;
    end
  endtask

  task automatic model_advance();
    int pick;
    pick = -1;
    if (m_ph == 0) begin
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && cl_req[(m_last + k) % 4]) pick = (m_last + k) % 4;
      if (pick >= 0) begin
        m_cl = pick;
        m_last = pick;
        m_mcs = pick;
        m_we = cl_we[pick];
        m_addr = cl_addr[pick];
        m_data = cl_data[pick];
        m_ph = 1;
        if (m_we) rmem[m_addr] = m_data;
        else m_rexp = rmem[m_addr];
      end
    end else m_ph = (m_ph == last_ph()) ? 0 : m_ph + 1;
  endtask

  task automatic step();
    check_outputs();
    ctrl_update();
    drive();
    model_advance();
    apply();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mc_state", 32'(mc_state), 0);
    chk("rst_mc_en", 32'(mc_en), 0);
    chk("rst_mc_read", 32'(mc_read), 0);
    chk("rst_mc_write", 32'(mc_write), 0);
    chk("rst_mc_address", 32'(mc_address), 0);
    chk("rst_mc_input_data", mc_input_data, 0);
    cl_req = '0;
    sticky = '0;
    apply();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ph = 0;
    m_last = 3;
    m_mcs = 0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    glog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 128; a++) begin
      cmem[a] = 8'($urandom);
      rmem[a] = cmem[a];
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr[i] = '0;
      cl_addr[i] = '0;
      cl_data[i] = '0;
    end
    cl_req = '0;
    cl_we = '0;
    sticky = '0;
    mode = 1;
    m_we = 1'b1;
    m_cl = 0;
    apply();
    @(negedge clk);
    do_reset();

    cl_req[0] = 1'b1; cl_we[0] = 1'b1; cl_addr[0] = 7'd10; cl_data[0] = 8'd10;
    run(4);
    chk("wr_ack_cnt", 32'(ack_cnt[0]), 1);
    cl_req[1] = 1'b1; cl_we[1] = 1'b0; cl_addr[1] = 7'd10;
    run(5);
    chk("rd_ack_cnt", 32'(ack_cnt[1]), 1);
    chk("readback", 32'(last_ack_rdata), 10);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cl_req[i] = 1'b1; cl_we[i] = 1'b1; cl_addr[i] = 7'(20 + i); cl_data[i] = 8'($urandom);
    end
    run(13);
    for (int k = 0; k < 4; k++) chk("contend_order", glog.size() > k ? glog[k] : 99, k);
    for (int i = 0; i < 4; i++) chk("contend_once", 32'(ack_cnt[i]), 1);

    do_reset();
    sticky = 4'b0101;
    cl_req[0] = 1'b1; cl_we[0] = 1'b1; cl_addr[0] = 7'd30;
    cl_req[2] = 1'b1; cl_we[2] = 1'b1; cl_addr[2] = 7'd31;
    run(13);
    for (int k = 0; k < 4; k++) chk("fair_order", glog.size() > k ? glog[k] : 99, (k % 2) * 2);
    sticky = '0;
    cl_req = '0;
    run(4);

    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    cl_req[3] = 1'b1; cl_we[3] = 1'b0; cl_addr[3] = 7'd10;
    for (int g = 0; g < 10 && m_ph != 1; g++) step();
    chk("abort_reach_issue", 32'(m_ph), 1);
    cl_req[3] = 1'b0;
    run(5);
    chk("abort_ack_once", 32'(ack_cnt[3]), 1);

    cl_req[1] = 1'b1; cl_we[1] = 1'b0; cl_addr[1] = 7'd3;
    for (int g = 0; g < 10 && m_ph != 2; g++) step();
    chk("rst_reach_wait", 32'(m_ph), 2);
    do_reset();
    run(6);
    chk("post_rst_acks", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]), 0);

    mode = 0;
    run(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: req  input  4  per-client request, bit i = client i.
REQ-004 SHALL have: we  input  4  per-client command, 1 = write, 0 = read.
REQ-005 SHALL have: addr  input  28  client i address at [7i+6:7i].
REQ-006 SHALL have: wdata  input  32  client i write data at [8i+7:8i].
REQ-007 SHALL have: ack  output  4  one-cycle completion pulse to the served client.
REQ-008 SHALL have: rdata  output  8  read data, valid only while an ack bit of a read is high.
REQ-009 SHALL have: mc_state  output  2  port select to memory controller.
REQ-010 SHALL have: mc_en  output  1  memory controller enable.
REQ-011 SHALL have: mc_read, mc_write  output  4 each  controller read/write lines, bit i = controller port i.
REQ-012 SHALL have: mc_address  output  28, mc_input_data  output  32  controller port address/data, same packing as addr/wdata.
REQ-013 SHALL have: mc_output_data  input  32  controller read data per port, same packing.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any req bit high, SHALL pick one client round-robin, latch its index, we, addr, wdata; go ISSUE; else stay IDLE.
REQ-016 Round-robin: search SHALL start at (last_grant+1) mod 4; last_grant updates on each pick.
REQ-017 ISSUE (one cycle): mc_state = index, mc_en = 1, mc_write[index] = latched we, mc_read[index] = !we, mc_address/mc_input_data slice index = latched values; all other mc_read/mc_write bits 0.
REQ-018 ISSUE transitions: write -> RESP; read -> WAIT.
REQ-019 WAIT: mc_state and mc_en held, mc_read/mc_write all 0; SHALL capture mc_output_data slice index into rdata register at end of cycle; go RESP.
REQ-020 RESP: ack[index] = 1 for exactly one cycle, rdata = captured value (reads), unchanged (writes); go IDLE.
REQ-021 Latency: req seen in IDLE at cycle T -> write ack at T+2, read ack at T+3.
REQ-022 Client rule: req, we, addr, wdata held stable until ack; arbiter samples them only in IDLE.
REQ-023 Client dropping req after pick SHALL NOT abort; transaction completes and ack is still pulsed.
REQ-024 Req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-025 Simultaneous requests: exactly one grant per pass; the others wait and are served in round-robin order, none starved beyond 3 intervening transactions.
REQ-026 mc_en SHALL be 0 and mc_read/mc_write all 0 in IDLE and RESP; mc_state holds last value outside ISSUE/WAIT.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, ack 0, rdata 0, mc_state 0, mc_en 0, mc_read 0, mc_write 0, mc_address 0, mc_input_data 0, last_grant 3 (client 0 wins first).
REQ-028 Reset mid-transaction SHALL abandon it with no ack; first post-reset pick follows REQ-027 priority.

Structure
REQ-029 Shared package mem_pkg SHALL hold NUM_PORTS=4, ADDR_W=7, DATA_W=8, and FSM state encoding.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs valid, index), combinational.

Verification
REQ-031 Reset: rst_n low mid-read -> all outputs 0 asynchronously, no ack after release.
REQ-032 Write: client 0 req, we=1, addr=10, wdata=10 -> ISSUE shows mc_state=0, mc_write[0]=1, address 10, data 10; ack[0] at T+2.
REQ-033 Read back: client 1 req, we=0, addr=10 -> mc_state=1, mc_read[1]=1; ack[1] at T+3 with rdata=10.
REQ-034 Contention: req=4'b1111 from reset -> grant order 0,1,2,3, each acked once, one idle cycle between.
REQ-035 Fairness: client 2 held high with client 0 re-requesting continuously -> grants alternate 0,2,0,2.
REQ-036 Abort-by-client: client 3 drops req in ISSUE -> transaction completes, ack[3] pulsed once.
